// File: rtl/sum_controller_pkg.sv
// Shared constants and state encoding for the summation pass controller.
package sum_controller_pkg;
  localparam int ADDR_W    = 8;
  localparam int DEFAULT_N = 150;
  localparam int RD_LAT    = 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    READ     = 3'd2,
    DRAIN    = 3'd3,
    DIV      = 3'd4,
    WAIT_DIV = 3'd5,
    DONE     = 3'd6
  } state_t;
endpackage

// File: rtl/sum_controller_if.sv
// Control/handshake bundle between the top-level controller, sample memories,
// accumulators and divider.
interface sum_controller_if #(
  parameter int ADDR_W = sum_controller_pkg::ADDR_W
);
  logic              start;
  logic              n_sel;
  logic [ADDR_W-1:0] n_samples;
  logic              div_done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              div_start;
  logic              busy;
  logic              done;

  modport master (
    output start, n_sel, n_samples, div_done,
    input  rd_en, rd_addr, acc_clr, acc_en, div_start, busy, done
  );

  modport slave (
    input  start, n_sel, n_samples, div_done,
    output rd_en, rd_addr, acc_clr, acc_en, div_start, busy, done
  );
endinterface

// File: rtl/sum_controller_sample_addr_counter.sv
// Sample-memory address counter with synchronous clear and a terminal-count
// flag at the programmed last address.
module sample_addr_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign tc = (cnt == last);
endmodule

// File: rtl/sum_controller.sv
// Sequences one summation pass: clear accumulators, stream N samples, drain
// the read pipeline, kick the divider and report completion.
module sum_controller #(
  parameter int ADDR_W    = sum_controller_pkg::ADDR_W,
  parameter int DEFAULT_N = sum_controller_pkg::DEFAULT_N
) (
  input  logic            clk,
  input  logic            reset,
  sum_controller_if.slave bus
);
  import sum_controller_pkg::*;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] n_lat;
  logic [ADDR_W-1:0] cnt_last;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_clr, cnt_en, cnt_tc;
  logic              rd_en;
  logic [RD_LAT-1:0] vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      n_lat <= '0;
    else if (state == IDLE && bus.start)
      n_lat <= bus.n_sel ? bus.n_samples : ADDR_W'(DEFAULT_N);
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE:     if (bus.start) state_nxt = CLEAR;
      CLEAR: begin
        cnt_clr   = 1'b1;
        state_nxt = (n_lat != '0) ? READ : DONE;
      end
      READ: begin
        // Stop at N-1 so the held idle address is the last one issued.
        if (cnt_tc) state_nxt = DRAIN;
        else        cnt_en    = 1'b1;
      end
      DRAIN:    state_nxt = DIV;
      DIV:      state_nxt = WAIT_DIV;
      WAIT_DIV: if (bus.div_done) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign cnt_last = n_lat - ADDR_W'(1);

  sample_addr_counter #(.W(ADDR_W)) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign rd_en = (state == READ);

  // acc_en tracks read data coming back RD_LAT cycles after rd_en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = cnt;
  assign bus.acc_clr   = (state == CLEAR);
  assign bus.acc_en    = vld_pipe[RD_LAT-1];
  assign bus.div_start = (state == DIV);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_sum_controller.sv
// Pass-level bench: expected read addresses are queued when a pass is issued
// and popped as rd_en beats appear; pulse timing is checked per pass.
module tb_sum_controller;
  import sum_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sum_controller_if #(.ADDR_W(ADDR_W)) bus ();

  sum_controller #(.ADDR_W(ADDR_W), .DEFAULT_N(DEFAULT_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_addr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [13:0] outs();
    return {bus.rd_en, bus.acc_en, bus.acc_clr, bus.div_start, bus.busy, bus.done, bus.rd_addr};
  endfunction

  task automatic run_pass(input logic sel, input logic [7:0] ns, input int div_at,
                          input int spur_a, input int spur_b, input bit hold, input int abort_at);
    int n, rc, limit, exp_dn;
    int n_clr, c_clr, n_rd, f_rd, l_rd, n_acc, f_acc, l_acc, n_ds, c_ds, n_dn, c_dn, n_busy, n_ovl;
    logic [7:0] last_addr;
    bit fin, aborted;
    n = sel ? int'(ns) : DEFAULT_N;
    for (int i = 0; i < n; i++) exp_addr_q.push_back(8'(i));
    n_clr = 0; c_clr = -1; n_rd = 0; f_rd = -1; l_rd = -1; n_acc = 0; f_acc = -1; l_acc = -1;
    n_ds = 0; c_ds = -1; n_dn = 0; c_dn = -1; n_busy = 0; n_ovl = 0;
    last_addr = '0; fin = 0; aborted = 0; rc = 0;
    limit = ((n == 0) ? 2 : div_at) + 10;
    while (!fin && rc <= limit) begin
      @(negedge clk);
      if (rc == 0) begin
        bus.start = 1'b1; bus.n_sel = sel; bus.n_samples = ns;
        check("idle_busy", {31'd0, bus.busy}, 0);
      end else if (rc == 1) begin
        bus.n_sel = ~sel; bus.n_samples = ~ns;
        if (!hold) bus.start = 1'b0;
      end
      bus.div_done = (rc == div_at) || (rc == spur_a) || (rc == spur_b);
      if (rc == abort_at) begin
        #1 reset = 1'b1;
        #1 check("abort_outs", {18'd0, outs()}, 0);
        bus.start = 1'b0; bus.div_done = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_hold", {18'd0, outs()}, 0);
        end
        reset = 1'b0;
        exp_addr_q.delete();
        fin = 1; aborted = 1;
      end else begin
        if (bus.acc_clr) begin n_clr++; c_clr = rc; end
        if (bus.rd_en) begin
          n_rd++; if (f_rd < 0) f_rd = rc; l_rd = rc; last_addr = bus.rd_addr;
          if (exp_addr_q.size() == 0) check("addr_extra", {24'd0, bus.rd_addr}, 32'hFFFF_FFFF);
          else check("rd_addr", {24'd0, bus.rd_addr}, {24'd0, exp_addr_q.pop_front()});
        end
        if (bus.acc_en) begin n_acc++; if (f_acc < 0) f_acc = rc; l_acc = rc; end
        if (bus.div_start) begin n_ds++; c_ds = rc; end
        if (bus.busy) n_busy++;
        if (int'(bus.acc_clr) + int'(bus.div_start) + int'(bus.done) > 1) n_ovl++;
        if (bus.done) begin n_dn++; c_dn = rc; fin = 1; end
      end
      rc++;
    end
    if (!aborted) begin
      exp_dn = (n == 0) ? 2 : div_at + 1;
      check("done_cnt", n_dn, 1);
      check("done_cyc", c_dn, exp_dn);
      check("clr_cnt", n_clr, 1);
      check("clr_cyc", c_clr, 1);
      check("busy_cnt", n_busy, exp_dn);
      check("pulse_ovl", n_ovl, 0);
      check("rd_cnt", n_rd, n);
      check("acc_cnt", n_acc, n);
      check("ds_cnt", n_ds, (n == 0) ? 0 : 1);
      check("addr_left", exp_addr_q.size(), 0);
      if (n > 0) begin
        check("rd_first", f_rd, 2);
        check("rd_last", l_rd, n + 1);
        check("acc_first", f_acc, 3);
        check("acc_last", l_acc, n + 2);
        check("ds_cyc", c_ds, n + 3);
        check("last_addr", {24'd0, last_addr}, n - 1);
        check("addr_hold", {24'd0, bus.rd_addr}, n - 1);
      end
      if (!hold) bus.start = 1'b0;
      bus.div_done = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.n_sel = 1'b0; bus.n_samples = '0; bus.div_done = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_outs", {18'd0, outs()}, 0);
    reset = 1'b0;
    @(negedge clk);

    run_pass(1'b0, 8'd0,   160, -1, -1, 1'b0, -1);  // default N
    run_pass(1'b1, 8'd1,   8,   -1, -1, 1'b0, -1);
    run_pass(1'b1, 8'd0,   -1,  1,  -1, 1'b0, -1);
    run_pass(1'b1, 8'd10,  20,  1,  5,  1'b1, -1);  // start held, stray div_done
    run_pass(1'b1, 8'd3,   10,  -1, -1, 1'b0, -1);
    run_pass(1'b0, 8'd0,   160, -1, -1, 1'b0, 50);  // reset mid-pass
    @(negedge clk);
    run_pass(1'b0, 8'd0,   155, -1, -1, 1'b0, -1);
    run_pass(1'b1, 8'd255, 262, -1, -1, 1'b0, -1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/sum_controller.md
SUM_CONTROLLER -- requirements
Module: sum_controller

Interface
REQ-001 Parameter: ADDR_W, 8, sample-memory address width and sample-count width.
REQ-002 Parameter: DEFAULT_N, 150, sample count used when n_sel is low.
REQ-003 Port: clk  input  1  clock; all state changes on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  level request to begin one summation pass; sampled only in IDLE.
REQ-006 Port: n_sel  input  1  count select: 1 uses n_samples, 0 uses DEFAULT_N; latched with start.
REQ-007 Port: n_samples  input  ADDR_W  runtime sample count, 0..255; latched with start.
REQ-008 Port: div_done  input  1  divider-finished pulse; honoured only in WAIT_DIV.
REQ-009 Port: rd_en  output  1  sample-memory read enable for the X and Y memories.
REQ-010 Port: rd_addr  output  ADDR_W  sample-memory read address.
REQ-011 Port: acc_clr  output  1  synchronous clear of the sum accumulators (sum x, sum y, sum xy, sum x^2).
REQ-012 Port: acc_en  output  1  accumulate enable, aligned with memory read data.
REQ-013 Port: div_start  output  1  single-cycle divider start pulse.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  single-cycle pass-complete pulse; this is the end1 handshake to the top-level controller.

Function
REQ-016 The FSM SHALL use the states IDLE, CLEAR, READ, DRAIN, DIV, WAIT_DIV and DONE.
REQ-017 IDLE: with start=1, latch N (n_samples if n_sel=1, else DEFAULT_N) and go to CLEAR; otherwise stay in IDLE.
REQ-018 CLEAR: assert acc_clr for one cycle and load rd_addr=0; go to READ if N!=0, otherwise go to DONE.
REQ-019 READ: assert rd_en and present rd_addr=0..N-1 on consecutive cycles; after the cycle with rd_addr=N-1, go to DRAIN.
REQ-020 Memory read latency is 1 cycle, so acc_en SHALL equal rd_en delayed by one register stage.
REQ-021 DRAIN: one cycle with rd_en=0 and acc_en=1 for the last sample; then go to DIV.
REQ-022 DIV: assert div_start for one cycle; then go to WAIT_DIV.
REQ-023 WAIT_DIV: stay until div_done=1, then go to DONE.
REQ-024 DONE: assert done for one cycle; then go to IDLE.
REQ-025 Timing, with start high in IDLE at cycle 0:
 - CLEAR at cycle 1
 - rd_en high in cycles 2..N+1
 - acc_en high in cycles 3..N+2
 - div_start at cycle N+3
REQ-026 In idle, rd_addr SHALL hold its last value. The address counter never wraps: the largest address issued is N-1, at most 254.
REQ-027 start SHALL be ignored while busy=1; a new pass starts only after returning to IDLE.
REQ-028 Changes to n_samples or n_sel after the latch SHALL have no effect on the running pass.
REQ-029 A div_done that arrives in any state other than WAIT_DIV SHALL be ignored and SHALL NOT be remembered.
REQ-030 If start=1 during DONE, the block SHALL return to IDLE and only then accept the request.
REQ-031 acc_clr, div_start and done SHALL each be high for exactly one cycle per pass and never high at the same time.

Reset
REQ-032 On reset: state=IDLE; rd_addr=0 and latched N=0; rd_en, acc_en, acc_clr, div_start, busy and done all 0.
REQ-033 Reset asserted mid-pass SHALL abort immediately. No div_start or done is issued for the aborted pass, and the accumulators are not cleared by reset.

Structure
REQ-034 Shared package contents:
 - state encoding (3-bit)
 - ADDR_W
 - DEFAULT_N=150
 - memory read-latency constant RD_LAT=1
REQ-035 The address counter SHALL be the sub-module sample_addr_counter, with synchronous clear, enable, and a terminal-count flag for value N-1.
REQ-036 All outputs SHALL be decoded from the registered state, except acc_en, which is registered.

Verification
REQ-037 n_sel=0, start pulse at cycle 0, div_done at cycle 160 -> acc_clr@1; rd_en@2..151 with rd_addr 0..149; acc_en@3..152; div_start@153; done@161; busy@1..161.
REQ-038 n_sel=1, n_samples=1 -> rd_en only at cycle 2 with rd_addr=0; acc_en only at cycle 3; div_start@4.
REQ-039 n_sel=1, n_samples=0 -> acc_clr@1; done@2; no rd_en, acc_en or div_start pulses.
REQ-040 start held high plus div_done pulses injected during READ -> no restart and no early done; only the div_done in WAIT_DIV completes the pass, and a second pass begins after IDLE.
REQ-041 reset asserted at cycle 50 of a 150-sample pass -> all outputs 0 within the same cycle and state=IDLE; the next start runs a full, correct pass.
REQ-042 n_sel=1, n_samples=255 -> last rd_addr=254 with no wrap; acc_en count equals 255.
